// File: rtl/gpu_pkg.sv
// ----------------------------------------------------------------------------
// gpu_pkg
// Shared types and default sizes for the SIMT divergence scheduler.
//   sched_state_t : scheduler FSM states (IDLE/SELECT/READY/DONE)
//   DEF_*         : default geometry used by the scheduler parameters
//   thread_mask_t : one bit per thread at the default block size
// ----------------------------------------------------------------------------
package gpu_pkg;

  localparam int DEF_THREADS  = 4;
  localparam int DEF_PC_BITS  = 8;
  localparam int DEF_CNT_BITS = 8;

  typedef logic [DEF_THREADS-1:0] thread_mask_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    READY  = 2'd2,
    DONE   = 2'd3
  } sched_state_t;

endpackage

// File: rtl/min_pc_select.sv
// ----------------------------------------------------------------------------
// min_pc_select
// Combinational argmin over the per-thread PCs of the live threads.
// Ports:
//   thread_pc_i  : per-thread program counters
//   live_mask_i  : threads that have not retired
//   min_pc_o     : smallest PC among live threads (all ones when none live)
//   eq_mask_o    : live threads whose PC equals min_pc_o (zero when none live)
// ----------------------------------------------------------------------------
module min_pc_select #(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int PC_BITS           = 8
) (
  input  logic [THREADS_PER_BLOCK-1:0][PC_BITS-1:0] thread_pc_i,
  input  logic [THREADS_PER_BLOCK-1:0]              live_mask_i,
  output logic [PC_BITS-1:0]                        min_pc_o,
  output logic [THREADS_PER_BLOCK-1:0]              eq_mask_o
);

  logic [PC_BITS-1:0] run_min;

  // Starting the reduction at all ones means a block whose only live PC is
  // all ones still selects it, and an empty block yields an empty eq_mask
  // without needing a separate "found" flag.
  always_comb begin
    run_min = '1;
    for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
      if (live_mask_i[i] && (thread_pc_i[i] < run_min)) begin
        run_min = thread_pc_i[i];
      end
    end
  end

  // Every live thread sitting at the minimum is issued together; this is
  // what lets diverged threads reconverge without any explicit stack.
  always_comb begin
    eq_mask_o = '0;
    for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
      eq_mask_o[i] = live_mask_i[i] && (thread_pc_i[i] == run_min);
    end
  end

  assign min_pc_o = run_min;

endmodule

// File: rtl/divergence_scheduler.sv
// ----------------------------------------------------------------------------
// divergence_scheduler
// Per-core SIMT scheduler that lets the threads of one block hold different
// PCs. Each round it issues the minimum PC among live threads together with
// the mask of threads sitting at that PC.
// Ports:
//   clk              : core clock
//   reset            : asynchronous active-low reset
//   start            : launch pulse, honoured in IDLE and DONE
//   thread_count     : number of threads enabled, sampled with start
//   update_valid     : UPDATE-stage pulse, honoured in READY only
//   decoded_ret      : issued instruction is RET
//   next_pc          : per-thread next PC from the PC units
//   current_pc       : PC to fetch
//   active_mask      : threads executing current_pc
//   pc_valid         : current_pc/active_mask may be fetched
//   done             : all enabled threads retired
//   divergence_count : saturating count of issues that left threads behind
// ----------------------------------------------------------------------------
module divergence_scheduler
  import gpu_pkg::*;
#(
  parameter int THREADS_PER_BLOCK = DEF_THREADS,
  parameter int PC_BITS           = DEF_PC_BITS,
  parameter int CNT_BITS          = DEF_CNT_BITS
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      start,
  input  logic [$clog2(THREADS_PER_BLOCK):0]        thread_count,
  input  logic                                      update_valid,
  input  logic                                      decoded_ret,
  input  logic [THREADS_PER_BLOCK-1:0][PC_BITS-1:0] next_pc,
  output logic [PC_BITS-1:0]                        current_pc,
  output logic [THREADS_PER_BLOCK-1:0]              active_mask,
  output logic                                      pc_valid,
  output logic                                      done,
  output logic [CNT_BITS-1:0]                       divergence_count
);

  localparam int TC_BITS = $clog2(THREADS_PER_BLOCK) + 1;

  sched_state_t                              state_q;
  logic [THREADS_PER_BLOCK-1:0][PC_BITS-1:0] thread_pc_q;
  logic [THREADS_PER_BLOCK-1:0]              live_q;
  logic [PC_BITS-1:0]                        current_pc_q;
  logic [THREADS_PER_BLOCK-1:0]              active_q;
  logic                                      pc_valid_q;
  logic                                      done_q;
  logic [CNT_BITS-1:0]                       div_q;

  logic [TC_BITS-1:0]                        clamped_count;
  logic [THREADS_PER_BLOCK-1:0]              launch_mask_d;
  logic [CNT_BITS-1:0]                       div_d;
  logic [PC_BITS-1:0]                        sel_min_pc;
  logic [THREADS_PER_BLOCK-1:0]              sel_eq_mask;

  // thread_count is one bit wider than needed, so values above the block
  // size are clamped before building the launch mask.
  always_comb begin
    clamped_count = thread_count;
    if (thread_count > TC_BITS'(THREADS_PER_BLOCK)) begin
      clamped_count = TC_BITS'(THREADS_PER_BLOCK);
    end
    launch_mask_d = '0;
    for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
      launch_mask_d[i] = (TC_BITS'(i) < clamped_count);
    end
  end

  // The divergence counter sticks at all ones instead of wrapping.
  assign div_d = (&div_q) ? div_q : div_q + CNT_BITS'(1);

  min_pc_select #(
    .THREADS_PER_BLOCK (THREADS_PER_BLOCK),
    .PC_BITS           (PC_BITS)
  ) u_min_pc_select (
    .thread_pc_i (thread_pc_q),
    .live_mask_i (live_q),
    .min_pc_o    (sel_min_pc),
    .eq_mask_o   (sel_eq_mask)
  );

  // Scheduler FSM. All outputs are registered here so the core sees stable
  // values for the whole READY window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      thread_pc_q  <= '0;
      live_q       <= '0;
      current_pc_q <= '0;
      active_q     <= '0;
      pc_valid_q   <= 1'b0;
      done_q       <= 1'b0;
      div_q        <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            thread_pc_q <= '0;
            live_q      <= launch_mask_d;
            div_q       <= '0;
            pc_valid_q  <= 1'b0;
            if (launch_mask_d == '0) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              done_q  <= 1'b0;
              state_q <= SELECT;
            end
          end
        end

        SELECT: begin
          if (live_q == '0) begin
            done_q     <= 1'b1;
            pc_valid_q <= 1'b0;
            active_q   <= '0;
            state_q    <= DONE;
          end else begin
            current_pc_q <= sel_min_pc;
            active_q     <= sel_eq_mask;
            pc_valid_q   <= 1'b1;
            if (sel_eq_mask != live_q) begin
              div_q <= div_d;
            end
            state_q <= READY;
          end
        end

        READY: begin
          if (update_valid) begin
            // Only threads that executed this instruction move; a RET
            // retires them instead of advancing their PC.
            for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
              if (active_q[i]) begin
                if (decoded_ret) begin
                  live_q[i] <= 1'b0;
                end else begin
                  thread_pc_q[i] <= next_pc[i];
                end
              end
            end
            pc_valid_q <= 1'b0;
            state_q    <= SELECT;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign current_pc       = current_pc_q;
  assign active_mask      = active_q;
  assign pc_valid         = pc_valid_q;
  assign done             = done_q;
  assign divergence_count = div_q;

endmodule

// File: tb/tb_divergence_scheduler.sv
// ----------------------------------------------------------------------------
// tb_divergence_scheduler
// Self-checking bench for divergence_scheduler: directed scenarios followed
// by randomized blocks, all compared against a thread-level reference model.
// ----------------------------------------------------------------------------
module tb_divergence_scheduler;

  localparam int T   = 4;
  localparam int PCB = 8;
  localparam int CB  = 8;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic                     start = 1'b0;
  logic [2:0]               thread_count = '0;
  logic                     update_valid = 1'b0;
  logic                     decoded_ret = 1'b0;
  logic [T-1:0][PCB-1:0]    next_pc = '0;
  logic [PCB-1:0]           current_pc;
  logic [T-1:0]             active_mask;
  logic                     pc_valid;
  logic                     done;
  logic [CB-1:0]            divergence_count;

  int checks = 0;
  int errors = 0;

  // Reference model: one PC and one alive flag per thread, plus the last
  // issue the scheduler should have made.
  int         mPc[T];
  logic [T-1:0] mLive;
  logic [T-1:0] mActive;
  int         mCur;
  int         mDiv;
  logic       mDone;
  logic       mValid;

  divergence_scheduler #(
    .THREADS_PER_BLOCK (T),
    .PC_BITS           (PCB),
    .CNT_BITS          (CB)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .thread_count     (thread_count),
    .update_valid     (update_valid),
    .decoded_ret      (decoded_ret),
    .next_pc          (next_pc),
    .current_pc       (current_pc),
    .active_mask      (active_mask),
    .pc_valid         (pc_valid),
    .done             (done),
    .divergence_count (divergence_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [T-1:0][PCB-1:0] allPc(input int v);
    logic [T-1:0][PCB-1:0] r;
    for (int i = 0; i < T; i++) r[i] = PCB'(v);
    return r;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < T; i++) mPc[i] = 0;
    mLive = '0; mActive = '0; mCur = 0; mDiv = 0; mDone = 0; mValid = 0;
  endtask

  task automatic modelStart(input int cnt);
    int n;
    n = (cnt > T) ? T : cnt;
    for (int i = 0; i < T; i++) begin
      mPc[i]   = 0;
      mLive[i] = (i < n);
    end
    mDiv = 0; mValid = 0; mDone = (n == 0);
  endtask

  task automatic modelSelect();
    int m;
    if (mLive == '0) begin
      mDone = 1; mValid = 0; mActive = '0;
    end else begin
      m = 1 << PCB;
      for (int i = 0; i < T; i++) if (mLive[i] && mPc[i] < m) m = mPc[i];
      for (int i = 0; i < T; i++) mActive[i] = mLive[i] && (mPc[i] == m);
      mCur = m; mValid = 1;
      if (mActive != mLive && mDiv < (1 << CB) - 1) mDiv++;
    end
  endtask

  task automatic modelUpdate(input logic ret, input logic [T-1:0][PCB-1:0] npc);
    for (int i = 0; i < T; i++) begin
      if (mActive[i]) begin
        if (ret) mLive[i] = 1'b0;
        else     mPc[i]   = int'(npc[i]);
      end
    end
    mValid = 0;
  endtask

  task automatic checkIssue(input string tag);
    checkOutput({tag, ".valid"}, pc_valid, mValid);
    checkOutput({tag, ".done"}, done, mDone);
    checkOutput({tag, ".mask"}, active_mask, mActive);
    checkOutput({tag, ".div"}, divergence_count, mDiv);
    if (mValid) checkOutput({tag, ".pc"}, current_pc, mCur);
  endtask

  // Launch a block and, if any threads are enabled, check its first issue.
  task automatic applyStimulus(input string tag, input int cnt);
    thread_count = 3'(cnt);
    start = 1'b1;
    tick();
    start = 1'b0;
    modelStart(cnt);
    checkOutput({tag, ".launch_done"}, done, mDone);
    checkOutput({tag, ".launch_valid"}, pc_valid, 1'b0);
    if (!mDone) begin
      tick();
      modelSelect();
      checkIssue(tag);
    end
  endtask

  // One UPDATE pulse: pc_valid must drop on the sampling edge and the next
  // issue (or done) must appear exactly one edge later.
  task automatic doUpdate(input string tag, input logic ret, input logic [T-1:0][PCB-1:0] npc);
    decoded_ret  = ret;
    next_pc      = npc;
    update_valid = 1'b1;
    tick();
    update_valid = 1'b0;
    decoded_ret  = 1'b0;
    modelUpdate(ret, npc);
    checkOutput({tag, ".gap_valid"}, pc_valid, 1'b0);
    tick();
    modelSelect();
    checkIssue(tag);
  endtask

  initial begin
    logic [T-1:0][PCB-1:0] npc;
    int cnt;
    int k;
    logic ret;

    // Reset state
    modelReset();
    tick();
    tick();
    checkOutput("rst.pc", current_pc, 0);
    checkOutput("rst.mask", active_mask, 0);
    checkOutput("rst.valid", pc_valid, 0);
    checkOutput("rst.done", done, 0);
    checkOutput("rst.div", divergence_count, 0);
    #2 reset = 1'b1;
    tick();

    // Ignored update pulse in IDLE
    next_pc = allPc(9);
    update_valid = 1'b1;
    tick();
    update_valid = 1'b0;
    tick();
    checkOutput("idle_ign.valid", pc_valid, 0);
    checkOutput("idle_ign.pc", current_pc, 0);

    // Convergent run
    applyStimulus("conv0", 4);
    checkOutput("conv0.const_mask", active_mask, 4'hF);
    for (int p = 0; p < 3; p++) begin
      doUpdate("conv", 1'b0, allPc(p + 1));
      checkOutput("conv.const_pc", current_pc, p + 1);
      checkOutput("conv.const_mask", active_mask, 4'hF);
    end
    doUpdate("conv_ret", 1'b1, allPc(0));
    checkOutput("conv_ret.const_done", done, 1);
    checkOutput("conv_ret.const_div", divergence_count, 0);

    // Divergence and reconvergence
    applyStimulus("div0", 4);
    doUpdate("div1", 1'b0, allPc(1));
    doUpdate("div2", 1'b0, allPc(2));
    npc[3] = 8'd6; npc[2] = 8'd6; npc[1] = 8'd3; npc[0] = 8'd3;
    doUpdate("div3", 1'b0, npc);
    checkOutput("div3.const_pc", current_pc, 3);
    checkOutput("div3.const_mask", active_mask, 4'b0011);
    for (int p = 4; p <= 6; p++) begin
      npc = allPc(8'hAA);
      npc[0] = PCB'(p); npc[1] = PCB'(p);
      doUpdate("div_step", 1'b0, npc);
    end
    checkOutput("div6.const_pc", current_pc, 6);
    checkOutput("div6.const_mask", active_mask, 4'hF);
    checkOutput("div6.const_div", divergence_count, 3);
    doUpdate("div_ret", 1'b1, allPc(0));

    // Partial blocks
    applyStimulus("part2", 2);
    checkOutput("part2.const_mask", active_mask, 4'b0011);
    doUpdate("part2_ret", 1'b1, allPc(0));
    applyStimulus("part0", 0);
    checkOutput("part0.const_done", done, 1);
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("part0.no_valid", pc_valid, 0);
    end

    // Split RET
    applyStimulus("split0", 2);
    npc = allPc(0); npc[0] = 8'd5; npc[1] = 8'd9;
    doUpdate("split1", 1'b0, npc);
    doUpdate("split_ret0", 1'b1, allPc(0));
    checkOutput("split_ret0.const_pc", current_pc, 9);
    checkOutput("split_ret0.const_mask", active_mask, 4'b0010);
    checkOutput("split_ret0.const_done", done, 0);
    doUpdate("split_ret1", 1'b1, allPc(0));
    checkOutput("split_ret1.const_done", done, 1);

    // Async reset mid-READY
    applyStimulus("ar0", 4);
    doUpdate("ar1", 1'b0, allPc(7));
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    modelReset();
    checkOutput("ar.pc", current_pc, 0);
    checkOutput("ar.mask", active_mask, 0);
    checkOutput("ar.valid", pc_valid, 0);
    checkOutput("ar.done", done, 0);
    checkOutput("ar.div", divergence_count, 0);
    tick();
    #2 reset = 1'b1;
    tick();

    // Update pulse during SELECT is ignored
    thread_count = 3'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    modelStart(4);
    next_pc = allPc($urandom_range(1, 200));
    decoded_ret = 1'b1;
    update_valid = 1'b1;
    tick();
    update_valid = 1'b0;
    decoded_ret = 1'b0;
    modelSelect();
    checkIssue("sel_ign");
    checkOutput("sel_ign.const_pc", current_pc, 0);

    // Start pulse during READY is ignored
    thread_count = 3'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checkIssue("ready_start_ign");
    doUpdate("ready_start_ign_ret", 1'b1, allPc(0));

    // Randomized blocks against the model
    for (int r = 0; r < 12; r++) begin
      cnt = $urandom_range(0, 7);
      applyStimulus("rnd_launch", cnt);
      k = 0;
      while (!mDone && k < 30) begin
        ret = ($urandom_range(0, 3) == 0);
        for (int i = 0; i < T; i++) begin
          npc[i] = ($urandom_range(0, 4) == 0) ? 8'hFF : PCB'($urandom_range(0, 12));
        end
        doUpdate("rnd", ret, npc);
        k++;
      end
      k = 0;
      while (!mDone && k < 2 * T) begin
        doUpdate("rnd_drain", 1'b1, allPc(0));
        k++;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
